// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the iterative AES-128 round sequencer.
// Holds the FSM state encoding, the round count and the round-index width,
// plus a helper that maps a round index to a round-key address.
package aes_ctrl_pkg;

    localparam int NR_AES128 = 10;
    localparam int RW        = $clog2(NR_AES128 + 1);

    localparam logic [RW-1:0] NR_IDX = RW'(NR_AES128);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_INIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    // Encryption walks the key schedule upwards, decryption walks it down.
    function automatic logic [RW-1:0] rk_index(input logic [RW-1:0] idx,
                                               input logic          dec);
        return dec ? (NR_IDX - idx) : idx;
    endfunction

endpackage

// File: rtl/aes_seq_counter.sv
// Round / key-expansion step counter with clear, load and increment.
// Ports: clk, rst (sync, active-high), clr, ld + ld_val, inc; cnt and term (cnt==NR).
// Priority is clear > load > increment; the counter holds otherwise.
module aes_seq_counter
    import aes_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld,
    input  logic          inc,
    input  logic [RW-1:0] ld_val,
    output logic [RW-1:0] cnt,
    output logic          term
);

    logic [RW-1:0] cnt_d;
    logic [RW-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = ld_val;
        end else if (inc) begin
            cnt_d = cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == NR_IDX);

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: accepts a block (and optional new key), runs key
// expansion if needed, the initial AddRoundKey and NR rounds, then offers the result.
// Ports: in_valid/in_ready + new_key in, out_valid/out_ready out, datapath strobes, busy.
// Optional AES_DECRYPT_EN adds mode (in) and inv (out) for descending round-key order.
// Latency: NR+2 cycles with a cached key, 2NR+2 with expansion; in_ready low until
// the result is consumed, so blocks never overlap. All outputs forced to 0 during rst.
module aes_round_sequencer
    import aes_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          new_key,
`ifdef AES_DECRYPT_EN
    input  logic          mode,
    output logic          inv,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic          load_data,
    output logic          load_key,
    output logic          kexp_en,
    output logic          rk_we,
    output logic [RW-1:0] rk_addr,
    output logic          init_ark,
    output logic          round_en,
    output logic          last_round,
    output logic          busy
);

    seq_state_t state_d, state_q;
    logic       key_ok_d, key_ok_q;
    logic       dec_d, dec_q;

    logic          cnt_clr, cnt_ld, cnt_inc;
    logic [RW-1:0] cnt;
    logic          cnt_term;

    aes_seq_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .ld     (cnt_ld),
        .inc    (cnt_inc),
        .ld_val (RW'(1)),
        .cnt    (cnt),
        .term   (cnt_term)
    );

    always_comb begin
        state_d    = state_q;
        key_ok_d   = key_ok_q;
        dec_d      = dec_q;
        cnt_clr    = 1'b0;
        cnt_ld     = 1'b0;
        cnt_inc    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load_data  = 1'b0;
        load_key   = 1'b0;
        kexp_en    = 1'b0;
        rk_we      = 1'b0;
        rk_addr    = '0;
        init_ark   = 1'b0;
        round_en   = 1'b0;
        last_round = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_data = 1'b1;
`ifdef AES_DECRYPT_EN
                    dec_d = mode;
`else
                    dec_d = 1'b0;
`endif
                    // No valid schedule in the store yet: expand even if the
                    // host did not ask for a new key.
                    if (new_key || !key_ok_q) begin
                        load_key = 1'b1;
                        rk_we    = 1'b1;
                        cnt_ld   = 1'b1;
                        state_d  = ST_KEYEXP;
                    end else begin
                        state_d  = ST_INIT;
                    end
                end
            end
            ST_KEYEXP: begin
                kexp_en = 1'b1;
                rk_we   = 1'b1;
                rk_addr = cnt;
                if (cnt_term) begin
                    key_ok_d = 1'b1;
                    state_d  = ST_INIT;
                end else begin
                    cnt_inc  = 1'b1;
                end
            end
            ST_INIT: begin
                init_ark = 1'b1;
                rk_addr  = rk_index('0, dec_q);
                cnt_ld   = 1'b1;
                state_d  = ST_ROUND;
            end
            ST_ROUND: begin
                round_en   = 1'b1;
                rk_addr    = rk_index(cnt, dec_q);
                last_round = cnt_term;
                if (cnt_term) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are held quiet for the whole reset cycle, in_ready included.
        if (rst) begin
            in_ready   = 1'b0;
            out_valid  = 1'b0;
            load_data  = 1'b0;
            load_key   = 1'b0;
            kexp_en    = 1'b0;
            rk_we      = 1'b0;
            rk_addr    = '0;
            init_ark   = 1'b0;
            round_en   = 1'b0;
            last_round = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            key_ok_q <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_ok_q <= key_ok_d;
            dec_q    <= dec_d;
        end
    end

    assign busy = !rst && (state_q != ST_IDLE);

`ifdef AES_DECRYPT_EN
    assign inv = !rst && dec_q && ((state_q == ST_INIT) || (state_q == ST_ROUND));
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

    localparam int NR = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       new_key;
    logic       mode;
    logic       inv_w;
    logic       out_valid;
    logic       out_ready;
    logic       load_data;
    logic       load_key;
    logic       kexp_en;
    logic       rk_we;
    logic [3:0] rk_addr;
    logic       init_ark;
    logic       round_en;
    logic       last_round;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit m_key_ok = 1'b0;

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .new_key    (new_key),
`ifdef AES_DECRYPT_EN
        .mode       (mode),
        .inv        (inv_w),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .load_data  (load_data),
        .load_key   (load_key),
        .kexp_en    (kexp_en),
        .rk_we      (rk_we),
        .rk_addr    (rk_addr),
        .init_ark   (init_ark),
        .round_en   (round_en),
        .last_round (last_round),
        .busy       (busy)
    );

`ifndef AES_DECRYPT_EN
    assign inv_w = 1'b0;
`endif

    // {in_ready, out_valid, load_data, load_key, kexp_en, rk_we, init_ark,
    //  round_en, last_round, busy, inv, rk_addr[3:0]}
    logic [14:0] dut_vec;
    assign dut_vec = {in_ready, out_valid, load_data, load_key, kexp_en, rk_we,
                      init_ark, round_en, last_round, busy, inv_w, rk_addr};

    function automatic logic [14:0] pack(bit ir, bit ov, bit ld, bit lk, bit ke,
                                         bit we, bit ia, bit re, bit lr, bit bz,
                                         bit iv, int addr);
        logic [3:0] a;
        a = 4'(addr);
        return {ir, ov, ld, lk, ke, we, ia, re, lr, bz, iv, a};
    endfunction

    // Expected outputs t cycles after accept, from the documented timeline:
    // t<0 idle, t=0 accept, then [key expansion], INIT, NR rounds, DONE.
    function automatic logic [14:0] model(bit kx, bit dec, int t);
        int base;
        int r;
        base = kx ? NR : 0;
        if (t < 0)              return pack(1,0,0,0,0,0,0,0,0,0,0,0);
        if (t == 0)             return pack(1,0,1,kx,0,kx,0,0,0,0,0,0);
        if (t <= base)          return pack(0,0,0,0,1,1,0,0,0,1,0,t);
        if (t == base + 1)      return pack(0,0,0,0,0,0,1,0,0,1,dec,dec ? NR : 0);
        if (t <= base + NR + 1) begin
            r = t - base - 1;
            return pack(0,0,0,0,0,0,0,1,(r == NR),1,dec,dec ? NR - r : r);
        end
        return pack(0,1,0,0,0,0,0,0,0,1,0,0);
    endfunction

    task automatic check(input logic [14:0] exp, input string tag);
        n_tests++;
        assert (dut_vec === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, dut_vec, exp);
        end
    endtask

    // One block: accept, run to completion (holding out_ready low for `hold`
    // DONE cycles), or pulse rst at cycle rst_at (0 = never).
    task automatic run_block(input bit nk, input bit md, input int hold,
                             input int rst_at, input string name);
        bit kx;
        bit dec;
        int done_t;
        kx = nk || !m_key_ok;
`ifdef AES_DECRYPT_EN
        dec = md;
`else
        dec = 1'b0;
`endif
        done_t = (kx ? NR : 0) + NR + 2;

        @(posedge clk); #1;
        in_valid  = 1'b1;
        new_key   = nk;
        mode      = md;
        out_ready = 1'b0;
        @(negedge clk);
        check(model(kx, dec, 0), $sformatf("%s_accept", name));

        for (int t = 1; t <= done_t + hold; t++) begin
            @(posedge clk); #1;
            // Inputs other than out_ready must be ignored while busy.
            in_valid  = 1'($urandom_range(0, 1));
            new_key   = 1'($urandom_range(0, 1));
            mode      = 1'($urandom_range(0, 1));
            out_ready = 1'b0;
            if (t == done_t + hold) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            if (t == rst_at) rst = 1'b1;
            @(negedge clk);
            if (rst) begin
                check(15'h0, $sformatf("%s_in_reset_t%0d", name, t));
                @(posedge clk); #1;
                rst       = 1'b0;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                m_key_ok  = 1'b0;
                @(negedge clk);
                check(model(0, 0, -1), $sformatf("%s_after_reset", name));
                return;
            end
            check(model(kx, dec, t), $sformatf("%s_t%0d", name, t));
            if (kx && t == NR) m_key_ok = 1'b1;
        end

        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check(model(kx, dec, -1), $sformatf("%s_idle", name));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        new_key   = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check(15'h0, "reset_outputs");
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check(model(0, 0, -1), "post_reset_idle");

        run_block(1'b0, 1'b0, 0, 0, "fresh_key");
        run_block(1'b0, 1'b0, 0, 0, "cached");
        run_block(1'b0, 1'b0, 5, 0, "stall");
        run_block(1'b0, 1'b0, 0, 6, "rst_round5");
        run_block(1'b0, 1'b0, 0, 0, "after_rst");
        run_block(1'b1, 1'b0, 0, 3, "rst_keyexp");
        run_block(1'b0, 1'b1, 1, 0, "dec_keyexp");
        run_block(1'b0, 1'b1, 0, 0, "dec_cached");
        for (int i = 0; i < 10; i++) begin
            run_block(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 0, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
